// File: rtl/keycode_event_if.sv
// Handshake bundle between the keycode event queue and its report producer / event consumer.
// The slave side is the queue itself; the master side feeds reports and drains events.
interface keycode_event_if #(
  parameter int SLOTS      = 6,
  parameter int KC_W       = 8,
  parameter int DEPTH      = 8,
  parameter int HEX_DIGITS = 2
);
  logic                       report_valid;
  logic                       report_ready;
  logic [SLOTS*KC_W-1:0]      report_keycodes;
  logic                       evt_valid;
  logic                       evt_ready;
  logic [KC_W-1:0]            evt_code;
  logic                       evt_press;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic [$clog2(SLOTS+1)-1:0] held_count;
  logic                       overflow;
  logic                       overflow_clr;
  logic [HEX_DIGITS*7-1:0]    hex_n;

  modport master (
    output report_valid, report_keycodes, evt_ready, overflow_clr,
    input  report_ready, evt_valid, evt_code, evt_press, fifo_count,
           held_count, overflow, hex_n
  );

  modport slave (
    input  report_valid, report_keycodes, evt_ready, overflow_clr,
    output report_ready, evt_valid, evt_code, evt_press, fifo_count,
           held_count, overflow, hex_n
  );
endinterface

// File: rtl/keycode_event_queue.sv
// Turns successive multi-slot HID keycode reports into a FIFO of press/release edge events,
// and mirrors the most recently queued keycode on active-low seven-segment digits.
module keycode_event_queue #(
  parameter int SLOTS           = 6,
  parameter int KC_W            = 8,
  parameter int DEPTH           = 8,
  parameter int HEX_DIGITS      = 2,
  parameter bit ROLLOVER_IGNORE = 1'b1
) (
  input logic           Clk,
  input logic           Reset,
  keycode_event_if.slave bus
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(SLOTS + 1);
  localparam int EW = KC_W + 1;

  localparam logic [IW-1:0]           LAST_IDX = IW'(SLOTS - 1);
  localparam logic [CW-1:0]           FULL_CNT = CW'(DEPTH);
  localparam logic [HEX_DIGITS*7-1:0] HEX_ZERO = {HEX_DIGITS{7'b1000000}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_PRS  = 2'd2;
  localparam logic [1:0] ST_UPD  = 2'd3;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic [KC_W-1:0]         prev  [SLOTS];
  logic [KC_W-1:0]         new_r [SLOTS];
  logic [HW-1:0]           held_count;

  logic [EW-1:0]           mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    evt_valid, evt_press, overflow;
  logic [KC_W-1:0]         evt_code;
  logic [HEX_DIGITS*7-1:0] hex_n;

  logic [KC_W-1:0]         cand;
  logic                    cand_press, in_other, seen, push_req, rollover;
  logic [HW-1:0]           held_nxt;
  logic                    do_pop, push_ok, drop;
  logic [CW-1:0]           count_nxt, count_after_pop;
  logic [PW-1:0]           rd_nxt;
  logic [EW-1:0]           head_nxt;
  logic [HEX_DIGITS*4-1:0] code_pad;
  logic [HEX_DIGITS*7-1:0] hex_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  // One slot per cycle: the candidate is an edge only if absent from the other report
  // and not already reported from an earlier slot of its own report.
  always_comb begin
    cand       = '0;
    cand_press = 1'b0;
    in_other   = 1'b0;
    seen       = 1'b0;
    if (state == ST_REL) cand = prev[idx];
    if (state == ST_PRS) begin
      cand       = new_r[idx];
      cand_press = 1'b1;
    end
    for (int j = 0; j < SLOTS; j++) begin
      if (state == ST_REL) begin
        if (new_r[j] == cand) in_other = 1'b1;
        if (j < int'(idx) && prev[j] == cand) seen = 1'b1;
      end else begin
        if (prev[j] == cand) in_other = 1'b1;
        if (j < int'(idx) && new_r[j] == cand) seen = 1'b1;
      end
    end
    push_req = (state == ST_REL || state == ST_PRS) && (cand != '0) && !in_other && !seen;
  end

  always_comb begin
    held_nxt = '0;
    rollover = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      logic dup;
      dup = 1'b0;
      for (int j = 0; j < i; j++)
        if (new_r[j] == new_r[i]) dup = 1'b1;
      if (new_r[i] != '0 && !dup) held_nxt = held_nxt + HW'(1);
      if (bus.report_keycodes[i*KC_W +: KC_W] == KC_W'(1)) rollover = 1'b1;
    end
  end

  // The head register is refilled from the pushed entry when the queue would otherwise be empty.
  always_comb begin
    do_pop          = evt_valid && bus.evt_ready;
    push_ok         = push_req && ((count < FULL_CNT) || do_pop);
    drop            = push_req && !push_ok;
    count_after_pop = count - CW'(do_pop);
    count_nxt       = count_after_pop + CW'(push_ok);
    rd_nxt          = rd_ptr + PW'(do_pop);
    head_nxt        = (count_after_pop == '0) ? {cand_press, cand} : mem[rd_nxt];
    code_pad        = (HEX_DIGITS*4)'(cand);
    hex_nxt         = '0;
    for (int d = 0; d < HEX_DIGITS; d++)
      hex_nxt[d*7 +: 7] = seg7(code_pad[d*4 +: 4]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      held_count <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        prev[i]  <= '0;
        new_r[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: if (bus.report_valid) begin
          for (int i = 0; i < SLOTS; i++) new_r[i] <= bus.report_keycodes[i*KC_W +: KC_W];
          idx <= '0;
          if (!(ROLLOVER_IGNORE && rollover)) state <= ST_REL;
        end
        ST_REL: if (idx == LAST_IDX) begin
          idx   <= '0;
          state <= ST_PRS;
        end else idx <= idx + IW'(1);
        ST_PRS: if (idx == LAST_IDX) begin
          idx   <= '0;
          state <= ST_UPD;
        end else idx <= idx + IW'(1);
        default: begin
          for (int i = 0; i < SLOTS; i++) prev[i] <= new_r[i];
          held_count <= held_nxt;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= {cand_press, cand};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_press <= 1'b0;
      overflow  <= 1'b0;
      hex_n     <= HEX_ZERO;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
        hex_n  <= hex_nxt;
      end
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      evt_valid <= (count_nxt != '0);
      if (count_nxt != '0) {evt_press, evt_code} <= head_nxt;
      if (drop) overflow <= 1'b1;
      else if (bus.overflow_clr) overflow <= 1'b0;
    end
  end

  assign bus.report_ready = (state == ST_IDLE);
  assign bus.evt_valid    = evt_valid;
  assign bus.evt_code     = evt_code;
  assign bus.evt_press    = evt_press;
  assign bus.fifo_count   = count;
  assign bus.held_count   = held_count;
  assign bus.overflow     = overflow;
  assign bus.hex_n        = hex_n;
endmodule

// File: tb/tb_keycode_event_queue.sv
// Self-checking bench for keycode_event_queue: directed scenarios plus randomized reports,
// all compared every cycle against a set-based reference model of reports and the event queue.
module tb_keycode_event_queue;
  logic Clk;
  logic Reset;

  keycode_event_if #(.SLOTS(6), .KC_W(8), .DEPTH(8), .HEX_DIGITS(2)) bus();

  keycode_event_queue #(
    .SLOTS(6), .KC_W(8), .DEPTH(8), .HEX_DIGITS(2), .ROLLOVER_IGNORE(1'b1)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nBad    = 0;

  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [7:0]  mPrev [6];
  logic [7:0]  mNew  [6];
  int          mPhase;
  int          mHeld, mHeldNew;
  bit          mOvf;
  logic [13:0] mHex;
  logic [8:0]  mq[$];
  bit          sValid [13];
  logic [7:0]  sCode  [13];
  bit          sPress [13];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nBad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [13:0] hexOf(input logic [7:0] code);
    return {font[code[7:4]], font[code[3:0]]};
  endfunction

  function automatic logic [47:0] mk(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    return {24'h0, k2, k1, k0};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 6; i++) begin
      mPrev[i] = 8'h00;
      mNew[i]  = 8'h00;
    end
    for (int i = 0; i < 13; i++) sValid[i] = 1'b0;
    mPhase = 0;
    mHeld  = 0;
    mOvf   = 1'b0;
    mHex   = {7'b1000000, 7'b1000000};
    mq.delete();
  endtask

  // Releases are keys of the old set missing from the new one, presses the reverse;
  // each event fires in the cycle of its key's first slot within its own scan pass.
  task automatic modelAccept(input logic [47:0] keys);
    int firstP[int];
    int firstN[int];
    for (int i = 0; i < 13; i++) sValid[i] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mNew[i] = keys[i*8 +: 8];
      if (mPrev[i] != 0 && !firstP.exists(int'(mPrev[i]))) firstP[int'(mPrev[i])] = i;
      if (mNew[i] != 0 && !firstN.exists(int'(mNew[i]))) firstN[int'(mNew[i])] = i;
    end
    foreach (firstP[k]) if (!firstN.exists(k)) begin
      sValid[1 + firstP[k]] = 1'b1;
      sCode[1 + firstP[k]]  = 8'(k);
      sPress[1 + firstP[k]] = 1'b0;
    end
    foreach (firstN[k]) if (!firstP.exists(k)) begin
      sValid[7 + firstN[k]] = 1'b1;
      sCode[7 + firstN[k]]  = 8'(k);
      sPress[7 + firstN[k]] = 1'b1;
    end
    mHeldNew = firstN.num();
  endtask

  task automatic checkAll();
    checkOutput("report_ready", 64'(bus.report_ready), 64'(mPhase == 0));
    checkOutput("evt_valid", 64'(bus.evt_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkOutput("evt_code", 64'(bus.evt_code), 64'(mq[0][7:0]));
      checkOutput("evt_press", 64'(bus.evt_press), 64'(mq[0][8]));
    end
    checkOutput("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
    checkOutput("held_count", 64'(bus.held_count), 64'(mHeld));
    checkOutput("overflow", 64'(bus.overflow), 64'(mOvf));
    checkOutput("hex_n", 64'(bus.hex_n), 64'(mHex));
  endtask

  // Drives one clock cycle of inputs, advances the model across the edge and checks every output.
  task automatic applyStimulus(input bit rst, input bit v, input logic [47:0] keys,
                               input bit er, input bit clr);
    bit pop, push, okPush, roll;
    logic [8:0] pe;
    Reset               = rst;
    bus.report_valid    = v;
    bus.report_keycodes = keys;
    bus.evt_ready       = er;
    bus.overflow_clr    = clr;
    pop    = (mq.size() > 0) && er;
    push   = (mPhase >= 1 && mPhase <= 12) && sValid[mPhase];
    pe     = push ? {sPress[mPhase], sCode[mPhase]} : 9'h0;
    okPush = push && (mq.size() < 8 || pop);
    roll   = 1'b0;
    for (int i = 0; i < 6; i++) if (keys[i*8 +: 8] == 8'h01) roll = 1'b1;
    @(posedge Clk);
    #1;
    if (rst) modelReset();
    else begin
      if (pop) void'(mq.pop_front());
      if (okPush) begin
        mq.push_back(pe);
        mHex = hexOf(pe[7:0]);
      end
      if (push && !okPush) mOvf = 1'b1;
      else if (clr) mOvf = 1'b0;
      if (mPhase == 0) begin
        if (v && !roll) begin
          modelAccept(keys);
          mPhase = 1;
        end
      end else if (mPhase == 13) begin
        for (int i = 0; i < 6; i++) mPrev[i] = mNew[i];
        mHeld  = mHeldNew;
        mPhase = 0;
      end else mPhase++;
    end
    checkAll();
  endtask

  task automatic sendReport(input logic [47:0] keys, input bit er, output int lowCycles);
    lowCycles = 0;
    applyStimulus(1'b0, 1'b1, keys, er, 1'b0);
    for (int n = 0; n < 40 && bus.report_ready !== 1'b1; n++) begin
      lowCycles++;
      applyStimulus(1'b0, 1'b0, 48'h0, er, 1'b0);
    end
    if (bus.report_ready !== 1'b1) checkOutput("scan_timeout", 64'(bus.report_ready), 64'h1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && bus.evt_valid === 1'b1; n++)
      applyStimulus(1'b0, 1'b0, 48'h0, 1'b1, 1'b0);
    checkOutput("drain_empty", 64'(bus.evt_valid), 64'h0);
  endtask

  initial begin
    int low;
    logic [47:0] keys;
    bit er, rst;
    modelReset();
    applyStimulus(1'b1, 1'b0, 48'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 48'h0, 1'b0, 1'b0);
    checkOutput("reset_evt_code", 64'(bus.evt_code), 64'h0);
    checkOutput("reset_evt_press", 64'(bus.evt_press), 64'h0);
    checkOutput("reset_hex", 64'(bus.hex_n), 64'h2040);

    sendReport(mk(8'h04, 8'h00, 8'h00), 1'b0, low);
    checkOutput("busy_cycles", 64'(low), 64'd13);
    checkOutput("first_code", 64'(bus.evt_code), 64'h04);
    checkOutput("first_press", 64'(bus.evt_press), 64'h1);
    checkOutput("first_held", 64'(bus.held_count), 64'h1);
    checkOutput("first_hex", 64'(bus.hex_n), {50'h0, 7'b1000000, 7'b0011001});
    drain();

    sendReport(mk(8'h16, 8'h04, 8'h00), 1'b0, low);
    checkOutput("add_count", 64'(bus.fifo_count), 64'h1);
    checkOutput("add_code", 64'(bus.evt_code), 64'h16);
    drain();
    sendReport(48'h0, 1'b0, low);
    checkOutput("rel_count", 64'(bus.fifo_count), 64'h2);
    checkOutput("rel_first", 64'(bus.evt_code), 64'h16);
    checkOutput("rel_held", 64'(bus.held_count), 64'h0);
    applyStimulus(1'b0, 1'b0, 48'h0, 1'b1, 1'b0);
    checkOutput("rel_second", 64'(bus.evt_code), 64'h04);
    checkOutput("rel_second_press", 64'(bus.evt_press), 64'h0);
    drain();

    sendReport(mk(8'h07, 8'h07, 8'h00), 1'b0, low);
    checkOutput("dup_count", 64'(bus.fifo_count), 64'h1);
    drain();
    sendReport(mk(8'h00, 8'h00, 8'h07), 1'b0, low);
    checkOutput("move_count", 64'(bus.fifo_count), 64'h0);

    sendReport({6{8'h01}}, 1'b0, low);
    checkOutput("rollover_busy", 64'(low), 64'h0);
    checkOutput("rollover_count", 64'(bus.fifo_count), 64'h0);
    sendReport(48'h0, 1'b0, low);
    checkOutput("rollover_prev_kept", 64'(bus.evt_code), 64'h07);
    drain();

    sendReport({8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04}, 1'b0, low);
    sendReport({8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A}, 1'b0, low);
    checkOutput("full_count", 64'(bus.fifo_count), 64'h8);
    checkOutput("full_ovf", 64'(bus.overflow), 64'h1);
    applyStimulus(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 64'(bus.overflow), 64'h0);
    sendReport(48'h0, 1'b1, low);
    checkOutput("pop_push_no_drop", 64'(bus.overflow), 64'h0);
    drain();

    applyStimulus(1'b0, 1'b1, mk(8'h04, 8'h05, 8'h00), 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) applyStimulus(1'b0, 1'b0, 48'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, mk(8'h06, 8'h00, 8'h00), 1'b0, 1'b0);
    checkOutput("midscan_valid", 64'(bus.evt_valid), 64'h0);
    checkOutput("midscan_ready", 64'(bus.report_ready), 64'h1);
    sendReport(mk(8'h04, 8'h00, 8'h00), 1'b0, low);
    checkOutput("post_reset_code", 64'(bus.evt_code), 64'h04);
    checkOutput("post_reset_press", 64'(bus.evt_press), 64'h1);
    drain();

    for (int c = 0; c < 3000; c++) begin
      keys = '0;
      for (int i = 0; i < 6; i++) begin
        int r;
        r = $urandom_range(0, 11);
        keys[i*8 +: 8] = (r < 4) ? 8'h00 : 8'(r);
      end
      if ($urandom_range(0, 39) == 0) keys[$urandom_range(0, 5)*8 +: 8] = 8'h01;
      er  = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(rst, $urandom_range(0, 1) == 1, keys, er, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
